// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package seq_mult_pkg;

    // Controller states: waiting, iterating Booth steps, presenting a fresh product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, at least 1, for sizing counters from parameters.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/booth_step_unit.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then an arithmetic right shift of {ACC,Q,q_1}.
// Purely combinational so it can be exercised on its own.
module booth_step_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc_in,
    input  logic [WIDTH:0]   q_in,
    input  logic             q_1_in,
    input  logic [WIDTH:0]   m_in,
    output logic [WIDTH+1:0] acc_out,
    output logic [WIDTH:0]   q_out,
    output logic             q_1_out
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    // Booth recoding on {Q[0],q_1}, then shift keeping the accumulator sign.
    always_comb begin
        m_ext = {m_in[WIDTH], m_in};
        sum   = acc_in;
        case ({q_in[0], q_1_in})
            2'b01:   sum = acc_in + m_ext;
            2'b10:   sum = acc_in - m_ext;
            default: sum = acc_in;
        endcase
        acc_out = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_out   = {sum[0], q_in[WIDTH:1]};
        q_1_out = q_in[0];
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier with start/done handshake.
// Operands are widened by one bit so a single datapath serves both signed
// and unsigned modes; WIDTH+1 Booth steps then give an exact product.
module seq_booth_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
);

    localparam int CNT_W = clog2(WIDTH + 2);
    // Count value reached once all WIDTH+1 Booth steps have been applied.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q,     m_d;
    logic [WIDTH+1:0]   acc_q,   acc_d;
    logic [WIDTH:0]     qr_q,    qr_d;
    logic               q1_q,    q1_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] z_q,     z_d;

    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH+1:0]   acc_step;
    logic [WIDTH:0]     qr_step;
    logic               q1_step;

    booth_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc_q),
        .q_in    (qr_q),
        .q_1_in  (q1_q),
        .m_in    (m_q),
        .acc_out (acc_step),
        .q_out   (qr_step),
        .q_1_out (q1_step)
    );

    // Widen operands: sign-extend in signed mode, zero-extend otherwise.
    always_comb begin
        a_ext = signed_op ? {A[WIDTH-1], A} : {1'b0, A};
        b_ext = signed_op ? {B[WIDTH-1], B} : {1'b0, B};
    end

    // Next-state and datapath update; everything holds unless changed below.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = a_ext;
                    acc_d   = '0;
                    qr_d    = b_ext;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    // The full product sits sign-extended in {ACC,Q}; keep the low 2*WIDTH bits.
                    z_d     = {acc_q[WIDTH-2:0], qr_q};
                    state_d = DONE;
                end else begin
                    acc_d = acc_step;
                    qr_d  = qr_step;
                    q1_d  = q1_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        Z     = z_q;
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench: fixed vectors and handshake/reset sequences on an
// 8-bit instance, random operands on 4-, 8- and 16-bit instances.
module tb_seq_booth_multiplier;

    logic clk;
    logic rst_n;

    logic       start4, s4, ready4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] z4;

    logic        start8, s8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;

    logic        start16, s16, ready16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] z16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    seq_booth_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_op(s4), .A(a4), .B(b4),
        .ready(ready4), .busy(busy4), .done(done4), .Z(z4)
    );

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(s8), .A(a8), .B(b8),
        .ready(ready8), .busy(busy8), .done(done8), .Z(z8)
    );

    seq_booth_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_op(s16), .A(a16), .B(b16),
        .ready(ready16), .busy(busy16), .done(done16), .Z(z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the mathematical product of the operands as integers, cut to 2*w bits.
    function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a,
                                             input logic [15:0] b, input logic s);
        longint av, bv, p, mask;
        mask = (longint'(1) << w) - 1;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        if (s && av[w-1]) av = av - (longint'(1) << w);
        if (s && bv[w-1]) bv = bv - (longint'(1) << w);
        p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic drive(input int w, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic sg);
        case (w)
            4: begin start4 = st; a4 = a[3:0]; b4 = b[3:0]; s4 = sg; end
            8: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; s8 = sg; end
            default: begin start16 = st; a16 = a; b16 = b; s16 = sg; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [31:0] get_z(input int w);
        case (w)
            4:       return {24'd0, z4};
            8:       return {16'd0, z8};
            default: return z16;
        endcase
    endfunction

    // One transaction: start, scramble inputs while running, wait (bounded) for done,
    // then confirm done drops and Z holds.
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output logic [31:0] z, output int lat);
        @(negedge clk);
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat = -1;
        z   = '0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (get_done(w)) begin
                lat = i;
                z   = get_z(w);
            end else begin
                drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        end
        if (lat < 0) z = get_z(w);
        @(negedge clk);
        check("done_one_cycle", {31'd0, get_done(w)}, 32'd0);
        check("z_held", get_z(w), z);
    endtask

    initial begin
        logic [31:0] z;
        logic [31:0] exp;
        logic [15:0] ra, rb;
        logic        rs;
        int          lat;
        int          n_done;
        int          w;

        vecs[0] = '{8'd7,   8'd3,   1'b0, 16'd21};
        vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vecs[2] = '{8'hF9,  8'd3,   1'b1, 16'hFFEB};
        vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[4] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
        vecs[5] = '{8'hFF,  8'h02,  1'b0, 16'h01FE};
        vecs[6] = '{8'hFF,  8'h02,  1'b1, 16'hFFFE};
        vecs[7] = '{8'h00,  8'h55,  1'b1, 16'h0000};
        vecs[8] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
        vecs[9] = '{8'h01,  8'hFF,  1'b1, 16'hFFFF};

        rst_n = 1'b0;
        drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);

        check("reset_ready", {31'd0, ready8}, 32'd1);
        check("reset_busy",  {31'd0, busy8},  32'd0);
        check("reset_done",  {31'd0, done8},  32'd0);
        check("reset_z",     {16'd0, z8},     32'd0);
        check("reset_ready_w4",  {31'd0, ready4},  32'd1);
        check("reset_ready_w16", {31'd0, ready16}, 32'd1);
        rst_n = 1'b1;

        // Fixed vectors on the 8-bit instance.
        for (int i = 0; i < 10; i++) begin
            do_op(8, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, vecs[i].s, z, lat);
            $display("vec %0d: A=%02h B=%02h signed=%0d Z=%04h latency=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, z[15:0], lat);
            check("vec_latency", lat, 32'd10);
            check("vec_z", z, {16'd0, vecs[i].exp});
        end

        // Start pulsed mid-run with other operands must be ignored.
        @(negedge clk);
        drive(8, 1'b1, 16'd8, 16'd6, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd8, 16'd6, 1'b0);
        n_done = 0;
        lat    = -1;
        z      = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check("busy_in_run", {31'd0, busy8}, 32'd1);
                check("ready_in_run", {31'd0, ready8}, 32'd0);
                drive(8, 1'b1, 16'd5, 16'd5, 1'b1);
            end else if (i == 4) begin
                drive(8, 1'b0, 16'd5, 16'd5, 1'b1);
            end
            if (done8) begin
                n_done++;
                lat = i;
                z   = {16'd0, z8};
            end
        end
        $display("handshake: 8*6 with start pulsed in RUN, Z=%0d dones=%0d latency=%0d", z, n_done, lat);
        check("busy_start_single_done", n_done, 32'd1);
        check("busy_start_z", z, 32'd48);
        check("busy_start_latency", lat, 32'd10);

        // Back-to-back: new start presented in the DONE cycle.
        @(negedge clk);
        drive(8, 1'b1, 16'd3, 16'd4, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (done8) lat = i;
        end
        check("b2b_first_latency", lat, 32'd10);
        check("b2b_first_z", {16'd0, z8}, 32'd12);
        check("b2b_ready_in_done", {31'd0, ready8}, 32'd1);
        drive(8, 1'b1, 16'd9, 16'd9, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        check("b2b_accepted_busy", {31'd0, busy8}, 32'd1);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (done8) lat = i;
        end
        $display("back-to-back: 3*4 then 9*9, second Z=%0d latency=%0d", z8, lat);
        check("b2b_second_latency", lat, 32'd10);
        check("b2b_second_z", {16'd0, z8}, 32'd81);

        // Reset in the middle of a run.
        @(negedge clk);
        drive(8, 1'b1, 16'd100, 16'd3, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_z",     {16'd0, z8},     32'd0);
        check("midrst_done",  {31'd0, done8},  32'd0);
        check("midrst_ready", {31'd0, ready8}, 32'd1);
        check("midrst_busy",  {31'd0, busy8},  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        $display("mid-run reset: dones after release=%0d Z=%0d", n_done, z8);
        check("midrst_no_stray_done", n_done, 32'd0);
        check("midrst_z_after", {16'd0, z8}, 32'd0);

        // Random operands on every width, both modes, with forced corner values first.
        for (int wi = 0; wi < 3; wi++) begin
            w = (wi == 0) ? 4 : ((wi == 1) ? 8 : 16);
            for (int n = 0; n < 24; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                if (n < 2) begin
                    ra = 16'hFFFF; rb = 16'hFFFF; rs = n[0];
                end else if (n < 4) begin
                    ra = 16'(1 << (w - 1)); rb = ra; rs = n[0];
                end
                do_op(w, ra, rb, rs, z, lat);
                exp = ref_prod(w, ra, rb, rs);
                $display("rand w=%0d A=%0h B=%0h signed=%0d Z=%0h latency=%0d",
                         w, ra & 16'((1 << w) - 1), rb & 16'((1 << w) - 1), rs, z, lat);
                check("rand_latency", lat, 32'(w + 2));
                check("rand_z", z, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
